rot_word: RTL and testbench

AES key-expansion RotWord stage: cyclic one-byte left rotation of a 4-byte word, [S0,S1,S2,S3] -> [S1,S2,S3,S0]. S0 is the most significant byte of the key-schedule word. Sits in the key-expansion datapath ahead of SubWord/Rcon XOR. Provides a registered output stage with valid tagging, plus a combinational bypass mode.

---
 rtl/aes_pkg.sv | 26 ++
 rtl/rot_word_core.sv | 19 +
 rtl/rot_word.sv | 78 +++++++
 tb/tb_rot_word.sv | 128 ++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and helpers for the key-expansion datapath.
// A word is four bytes held MSB-first: index 3 is byte S0, index 0 is byte S3.
package aes_pkg;

  localparam int AES_BYTE_W     = 8;
  localparam int AES_WORD_BYTES = 4;

  typedef logic [AES_BYTE_W-1:0]                aes_byte_t;
  typedef aes_byte_t [AES_WORD_BYTES-1:0]       aes_word_t;

  // Source lane feeding destination lane k for a left rotation by n lanes.
  function automatic int rot_src_lane(input int k, input int n);
    return (((k + n) % AES_WORD_BYTES) + AES_WORD_BYTES) % AES_WORD_BYTES;
  endfunction

  // Byte-lane left rotation of a word: result byte k = w byte (k+n) mod 4.
  function automatic aes_word_t rot_word(input aes_word_t w, input int n);
    aes_word_t r;
    r = '0;
    for (int k = 0; k < AES_WORD_BYTES; k++) begin
      r[AES_WORD_BYTES-1-k] = w[AES_WORD_BYTES-1-rot_src_lane(k, n)];
    end
    return r;
  endfunction

endpackage

// File: rtl/rot_word_core.sv
// Purely combinational byte-lane permutation: out lane k takes in lane (k+ROT) mod 4.
// Lane 0 is the most significant BYTE_W bits of the packed word.
module rot_word_core
  import aes_pkg::*;
#(
  parameter int BYTE_W = 8,
  parameter int ROT    = 1
) (
  input  logic [AES_WORD_BYTES*BYTE_W-1:0] in_word,
  output logic [AES_WORD_BYTES*BYTE_W-1:0] out_word
);

  for (genvar k = 0; k < AES_WORD_BYTES; k++) begin : g_lane
    localparam int SRC = rot_src_lane(k, ROT);
    assign out_word[(AES_WORD_BYTES-1-k)*BYTE_W +: BYTE_W] =
      in_word[(AES_WORD_BYTES-1-SRC)*BYTE_W +: BYTE_W];
  end

endmodule

// File: rtl/rot_word.sv
// AES RotWord stage with valid tagging; latency 1 when REGISTERED=1, else combinational.
// No backpressure: a word is accepted every cycle.
module rot_word
  import aes_pkg::*;
#(
  parameter int BYTE_W     = 8,
  parameter int ROT        = 1,
  parameter int REGISTERED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] S0_in,
  input  logic [BYTE_W-1:0] S1_in,
  input  logic [BYTE_W-1:0] S2_in,
  input  logic [BYTE_W-1:0] S3_in,
  output logic              out_valid,
  output logic [BYTE_W-1:0] D0_out,
  output logic [BYTE_W-1:0] D1_out,
  output logic [BYTE_W-1:0] D2_out,
  output logic [BYTE_W-1:0] D3_out
);

  localparam int WORD_W = AES_WORD_BYTES * BYTE_W;

  if (ROT < 0 || ROT > 3 || BYTE_W < 1) begin : g_param_err
    $fatal(1, "rot_word: illegal parameters ROT=%0d BYTE_W=%0d", ROT, BYTE_W);
  end

  logic [WORD_W-1:0] in_word;
  logic [WORD_W-1:0] rot_w;
  logic [WORD_W-1:0] out_word;
  logic              out_vld;

  assign in_word = {S0_in, S1_in, S2_in, S3_in};

  rot_word_core #(
    .BYTE_W (BYTE_W),
    .ROT    (ROT)
  ) u_core (
    .in_word  (in_word),
    .out_word (rot_w)
  );

  if (REGISTERED != 0) begin : g_reg
    logic [WORD_W-1:0] word_d, word_q;
    logic              valid_d, valid_q;

    // Data loads every cycle; consumers qualify it with out_valid only.
    always_comb begin
      word_d  = rot_w;
      valid_d = in_valid;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        word_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        word_q  <= word_d;
        valid_q <= valid_d;
      end
    end

    assign out_word = word_q;
    assign out_vld  = valid_q;
  end else begin : g_comb
    assign out_word = rot_w;
    assign out_vld  = in_valid;
  end

  assign out_valid = out_vld;
  assign D0_out    = out_word[3*BYTE_W +: BYTE_W];
  assign D1_out    = out_word[2*BYTE_W +: BYTE_W];
  assign D2_out    = out_word[1*BYTE_W +: BYTE_W];
  assign D3_out    = out_word[0*BYTE_W +: BYTE_W];

endmodule

// File: tb/tb_rot_word.sv
// Directed vector bench for rot_word: registered default build plus
// combinational ROT=1 and ROT=2 builds.
module tb_rot_word;
  import aes_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] s0, s1, s2, s3;
  logic       out_valid;
  logic [7:0] d0, d1, d2, d3;

  logic       c_valid;
  logic [7:0] c_s0, c_s1, c_s2, c_s3;
  logic       c1_valid, c2_valid;
  logic [7:0] c1_d0, c1_d1, c1_d2, c1_d3;
  logic [7:0] c2_d0, c2_d1, c2_d2, c2_d3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rot_word u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .S0_in(s0), .S1_in(s1), .S2_in(s2), .S3_in(s3),
    .out_valid(out_valid),
    .D0_out(d0), .D1_out(d1), .D2_out(d2), .D3_out(d3)
  );

  rot_word #(.BYTE_W(8), .ROT(1), .REGISTERED(0)) u_comb1 (
    .clk(clk), .rst(rst), .in_valid(c_valid),
    .S0_in(c_s0), .S1_in(c_s1), .S2_in(c_s2), .S3_in(c_s3),
    .out_valid(c1_valid),
    .D0_out(c1_d0), .D1_out(c1_d1), .D2_out(c1_d2), .D3_out(c1_d3)
  );

  rot_word #(.BYTE_W(8), .ROT(2), .REGISTERED(0)) u_comb2 (
    .clk(clk), .rst(rst), .in_valid(c_valid),
    .S0_in(c_s0), .S1_in(c_s1), .S2_in(c_s2), .S3_in(c_s3),
    .out_valid(c2_valid),
    .D0_out(c2_d0), .D1_out(c2_d1), .D2_out(c2_d2), .D3_out(c2_d3)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] in_w;
    logic        exp_vld;
    logic [31:0] exp_w;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    // Word presented during reset is dropped; reset mid-stream clears output.
    vecs[0]  = '{1'b1, 1'b1, 32'h01020304, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b0, 1'b1, 32'h01020304, 1'b1, 32'h02030401};
    vecs[2]  = '{1'b0, 1'b1, 32'hFFAA5500, 1'b1, 32'hAA5500FF};
    vecs[3]  = '{1'b0, 1'b1, 32'h67204675, 1'b1, 32'h20467567};
    vecs[4]  = '{1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5};
    vecs[5]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000000};
    vecs[6]  = '{1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF};
    vecs[7]  = '{1'b0, 1'b1, 32'h01020304, 1'b1, 32'h02030401};
    vecs[8]  = '{1'b1, 1'b1, 32'h01020304, 1'b0, 32'h00000000};
    vecs[9]  = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 32'hADBEEFDE};
    vecs[10] = '{1'b0, 1'b0, 32'h12345678, 1'b0, 32'h34567812};

    rst = 1'b1; in_valid = 1'b0; {s0, s1, s2, s3} = 32'hCAFEF00D;
    c_valid = 1'b0; {c_s0, c_s1, c_s2, c_s3} = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_vld",  {31'd0, out_valid}, 32'd0);
    chk("reset_data", {d0, d1, d2, d3},   32'd0);

    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst;
      in_valid = vecs[i].vld;
      {s0, s1, s2, s3} = vecs[i].in_w;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_vld", i),  {31'd0, out_valid}, {31'd0, vecs[i].exp_vld});
      chk($sformatf("vec%0d_data", i), {d0, d1, d2, d3},   vecs[i].exp_w);
    end

    // Registered output must hold between edges.
    {s0, s1, s2, s3} = 32'h0BADC0DE;
    in_valid = 1'b1;
    #3;
    chk("hold_data", {d0, d1, d2, d3}, 32'h34567812);

    // Combinational builds: outputs change with no clock edge involved.
    @(negedge clk);
    c_valid = 1'b1; {c_s0, c_s1, c_s2, c_s3} = 32'h01020304;
    #1;
    chk("comb1_vld",  {31'd0, c1_valid},               32'd1);
    chk("comb1_data", {c1_d0, c1_d1, c1_d2, c1_d3},    32'h02030401);
    chk("comb2_data", {c2_d0, c2_d1, c2_d2, c2_d3},    32'h03040102);
    c_valid = 1'b0; {c_s0, c_s1, c_s2, c_s3} = 32'h67204675;
    #1;
    chk("comb1_vld0",  {31'd0, c1_valid},              32'd0);
    chk("comb2_vld0",  {31'd0, c2_valid},              32'd0);
    chk("comb1_key",   {c1_d0, c1_d1, c1_d2, c1_d3},   32'h20467567);
    chk("comb2_key",   {c2_d0, c2_d1, c2_d2, c2_d3},   32'h46756720);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] w;
      w = $urandom;
      {c_s0, c_s1, c_s2, c_s3} = w;
      #1;
      chk($sformatf("rand%0d_rot1", i), {c1_d0, c1_d1, c1_d2, c1_d3}, rot_word(w, 1));
      chk($sformatf("rand%0d_rot2", i), {c2_d0, c2_d1, c2_d2, c2_d3}, rot_word(w, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
